// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between the icache
// and the dcache, with a single transaction outstanding at a time.
// Optional build macro CACHE_ARB_ROUND_ROBIN_EN: ties alternate between the
// two caches instead of always going to the dcache.
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept one request
// ISSUE | drive latched request to memory until m_req_ready
// WAIT  | request accepted by memory; wait for m_resp_valid
// RESP  | one-cycle response strobe to the owning cache
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_rw,
  input  logic [LINE_W-1:0] i_req_wdata,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_rw,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic              m_req_rw,
  output logic [LINE_W-1:0] m_req_wdata,
  input  logic              m_resp_valid,
  input  logic [LINE_W-1:0] m_resp_data,
  output logic              grant_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                grant_d_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                any_valid;
  logic                win_d;
  logic                accept;
  logic                capture;

  assign any_valid = i_req_valid | d_req_valid;
  // Acceptance is suppressed while reset is held so no requester sees ready.
  assign accept    = (state_q == IDLE) & any_valid & ~RESET;
  // Response is taken either alongside the issue handshake or later in WAIT.
  assign capture   = ((state_q == ISSUE) & m_req_ready & m_resp_valid) |
                     ((state_q == WAIT) & m_resp_valid);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Tie-break: favour whichever cache was not granted last.
  always_comb begin
    win_d = d_req_valid & (~i_req_valid | ~last_d_q);
  end

  // Last-grant flop; resets to icache so the first tie goes to the dcache.
  always_ff @(posedge clk) begin
    if (RESET) begin
      last_d_q <= 1'b0;
    end else if (accept) begin
      last_d_q <= win_d;
    end
  end
`else
  assign win_d = d_req_valid;
`endif

  // State register plus the latched request and captured response line.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_d_q <= win_d;
        addr_q    <= win_d ? d_req_addr  : i_req_addr;
        rw_q      <= win_d ? d_req_rw    : i_req_rw;
        wdata_q   <= win_d ? d_req_wdata : i_req_wdata;
        rdata_q   <= '0;
      end
      if (capture) begin
        rdata_q <= rw_q ? '0 : m_resp_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   if (m_req_ready) state_d = m_resp_valid ? RESP : WAIT;
      WAIT:    if (m_resp_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: request fields only visible in ISSUE, data only in owner's RESP.
  always_comb begin
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = 1'b0;
    m_req_addr   = '0;
    m_req_rw     = 1'b0;
    m_req_wdata  = '0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    i_resp_data  = '0;
    d_resp_data  = '0;
    grant_d      = grant_d_q;
    i_req_ready  = accept & ~win_d;
    d_req_ready  = accept & win_d;
    if (state_q == ISSUE) begin
      m_req_valid = 1'b1;
      m_req_addr  = addr_q;
      m_req_rw    = rw_q;
      m_req_wdata = wdata_q;
    end
    if (state_q == RESP) begin
      if (grant_d_q) begin
        d_resp_valid = 1'b1;
        d_resp_data  = rdata_q;
      end else begin
        i_resp_valid = 1'b1;
        i_resp_data  = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          RESET;
  logic          i_req_valid, i_req_rw, i_req_ready, i_resp_valid;
  logic [AW-1:0] i_req_addr;
  logic [LW-1:0] i_req_wdata, i_resp_data;
  logic          d_req_valid, d_req_rw, d_req_ready, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_wdata, d_resp_data;
  logic          m_req_valid, m_req_ready, m_req_rw, m_resp_valid, grant_d;
  logic [AW-1:0] m_req_addr;
  logic [LW-1:0] m_req_wdata, m_resp_data;

  int compared = 0;
  int mismatched = 0;

  // transaction-level reference model
  bit            mdl_busy = 0;
  bit            mdl_sent = 0;
  bit            mdl_have_line = 0;
  bit            mdl_grant = 0;
  bit            mdl_last_d = 0;
  logic [AW-1:0] mdl_addr = '0;
  bit            mdl_rw = 0;
  logic [LW-1:0] mdl_wdata = '0;
  logic [LW-1:0] mdl_line = '0;

  int            n_acc;
  logic [3:0]    order;
  logic [LW-1:0] line_l;
  logic [LW-1:0] wline;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .RESET(RESET),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_rw(i_req_rw),
    .i_req_wdata(i_req_wdata), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_rw(d_req_rw),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_rw(m_req_rw), .m_req_wdata(m_req_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] obs_vec();
    return {89'd0, i_req_ready, i_resp_valid, i_resp_data,
            d_req_ready, d_resp_valid, d_resp_data,
            m_req_valid, m_req_addr, m_req_rw, m_req_wdata, grant_d};
  endfunction

  // tie rule straight from the arbitration policy
  function automatic bit pick_d();
    if (!d_req_valid) return 1'b0;
    if (!i_req_valid) return 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    return !mdl_last_d;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [511:0] model_expect();
    bit            acc, wd, issuing, resp, e_iv, e_dv;
    logic [LW-1:0] e_id, e_dd;
    acc     = !mdl_busy && !RESET && (i_req_valid || d_req_valid);
    wd      = pick_d();
    issuing = mdl_busy && !mdl_sent;
    resp    = mdl_busy && mdl_have_line;
    e_iv    = resp && !mdl_grant;
    e_dv    = resp && mdl_grant;
    e_id    = e_iv ? mdl_line : '0;
    e_dd    = e_dv ? mdl_line : '0;
    return {89'd0, acc && !wd, e_iv, e_id, acc && wd, e_dv, e_dd,
            issuing, issuing ? mdl_addr : '0, issuing && mdl_rw,
            issuing ? mdl_wdata : '0, mdl_grant};
  endfunction

  task automatic model_step();
    bit wd;
    if (RESET) begin
      mdl_busy = 0; mdl_sent = 0; mdl_have_line = 0;
      mdl_grant = 0; mdl_last_d = 0;
    end else if (!mdl_busy) begin
      if (i_req_valid || d_req_valid) begin
        wd         = pick_d();
        mdl_busy   = 1;
        mdl_sent   = 0;
        mdl_have_line = 0;
        mdl_grant  = wd;
        mdl_last_d = wd;
        mdl_addr   = wd ? d_req_addr : i_req_addr;
        mdl_rw     = wd ? d_req_rw : i_req_rw;
        mdl_wdata  = wd ? d_req_wdata : i_req_wdata;
      end
    end else if (!mdl_sent) begin
      if (m_req_ready) begin
        mdl_sent = 1;
        if (m_resp_valid) begin
          mdl_have_line = 1;
          mdl_line = mdl_rw ? '0 : m_resp_data;
        end
      end
    end else if (!mdl_have_line) begin
      if (m_resp_valid) begin
        mdl_have_line = 1;
        mdl_line = mdl_rw ? '0 : m_resp_data;
      end
    end else begin
      mdl_busy = 0; mdl_sent = 0; mdl_have_line = 0;
    end
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [511:0] e;
    #1;
    e = model_expect();
    check("cycle_model", obs_vec(), e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 0; i_req_addr = '0; i_req_rw = 0; i_req_wdata = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_rw = 0; d_req_wdata = '0;
    m_req_ready = 0; m_resp_valid = 0; m_resp_data = '0;
  endtask

  initial begin
    RESET = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    cycle();
    i_req_valid = 1; d_req_valid = 1;
    #1;
    check("reset_no_ready", 512'({i_req_ready, d_req_ready}), '0);
    cycle();
    idle_inputs();
    #1;
    check("reset_outputs", obs_vec(), '0);
    cycle();
    RESET = 0;

    // d read 0x1040, memory answers alongside the handshake
    d_req_valid = 1; d_req_addr = 32'h0000_1040; d_req_rw = 0;
    d_req_wdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("t1_d_ready", 512'({i_req_ready, d_req_ready}), 512'(2'b01));
    cycle();
    d_req_valid = 0; m_req_ready = 1; m_resp_valid = 1; m_resp_data = {16{8'hA5}};
    #1;
    check("t1_m_valid", 512'(m_req_valid), 512'(1'b1));
    check("t1_m_addr", 512'(m_req_addr), 512'(32'h0000_1040));
    cycle();
    idle_inputs();
    #1;
    check("t1_d_resp_valid", 512'({i_resp_valid, d_resp_valid}), 512'(2'b01));
    check("t1_d_resp_data", 512'(d_resp_data), 512'({16{8'hA5}}));
    cycle();
    cycle();

    // i read, memory stalls 2 cycles then ready+response together
    i_req_valid = 1; i_req_addr = 32'h0000_3000; i_req_rw = 0;
    #1;
    check("t2_i_ready", 512'({i_req_ready, d_req_ready}), 512'(2'b10));
    cycle();
    idle_inputs();
    cycle();
    cycle();
    line_l = {$urandom, $urandom, $urandom, $urandom};
    m_req_ready = 1; m_resp_valid = 1; m_resp_data = line_l;
    cycle();
    idle_inputs();
    #1;
    check("t2_i_resp_valid", 512'({i_resp_valid, d_resp_valid}), 512'(2'b10));
    check("t2_i_resp_data", 512'(i_resp_data), 512'(line_l));
    cycle();
    cycle();

    // d write 0x2000, memory not ready for 5 cycles
    wline = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
    d_req_valid = 1; d_req_addr = 32'h0000_2000; d_req_rw = 1; d_req_wdata = wline;
    cycle();
    d_req_valid = 0; d_req_addr = 32'hDEAD_BEEF; d_req_rw = 0; d_req_wdata = '1;
    for (int k = 0; k < 6; k++) begin
      m_req_ready = (k == 5);
      #1;
      check("t3_m_fields", 512'({m_req_valid, m_req_addr, m_req_rw, m_req_wdata}),
            512'({1'b1, 32'h0000_2000, 1'b1, wline}));
      cycle();
    end
    m_req_ready = 0; m_resp_valid = 1; m_resp_data = '1;
    #1;
    check("t3_wait_no_mreq", 512'(m_req_valid), '0);
    cycle();
    idle_inputs();
    #1;
    check("t3_d_resp", 512'({d_resp_valid, d_resp_data}), 512'({1'b1, 128'd0}));
    cycle();
    cycle();

    // both caches valid back-to-back: grant order
    RESET = 1;
    cycle();
    RESET = 0;
    i_req_valid = 1; d_req_valid = 1; i_req_addr = 32'h100; d_req_addr = 32'h200;
    m_req_ready = 1; m_resp_valid = 1; m_resp_data = {$urandom, $urandom, $urandom, $urandom};
    n_acc = 0; order = '0;
    for (int k = 0; k < 40 && n_acc < 4; k++) begin
      #1;
      if (d_req_ready) begin order = {order[2:0], 1'b1}; n_acc++; end
      else if (i_req_ready) begin order = {order[2:0], 1'b0}; n_acc++; end
      cycle();
    end
    check("t4_count", 512'(n_acc), 512'(4));
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    check("t4_order", 512'(order), 512'(4'b1010));
`else
    check("t4_order", 512'(order), 512'(4'b1111));
`endif
    i_req_valid = 0; d_req_valid = 0;
    for (int k = 0; k < 3; k++) cycle();
    idle_inputs();
    cycle();

    // reset in WAIT, then stale memory response
    i_req_valid = 1; i_req_addr = 32'h0000_4000;
    cycle();
    idle_inputs();
    m_req_ready = 1;
    cycle();
    m_req_ready = 0; RESET = 1;
    cycle();
    RESET = 0; m_resp_valid = 1; m_resp_data = '1;
    #1;
    check("t5_after_reset", obs_vec(), '0);
    cycle();
    m_resp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t5_no_resp", 512'({i_resp_valid, d_resp_valid}), '0);
      cycle();
    end
    i_req_valid = 1; i_req_addr = 32'h0000_5000;
    #1;
    check("t5_new_accept", 512'(i_req_ready), 512'(1'b1));
    cycle();
    idle_inputs();
    line_l = {$urandom, $urandom, $urandom, $urandom};
    m_req_ready = 1; m_resp_valid = 1; m_resp_data = line_l;
    cycle();
    idle_inputs();
    #1;
    check("t5_i_resp", 512'({i_resp_valid, i_resp_data}), 512'({1'b1, line_l}));
    cycle();

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      RESET        = ($urandom_range(0, 59) == 0);
      i_req_valid  = ($urandom_range(0, 2) == 0);
      d_req_valid  = ($urandom_range(0, 2) == 0);
      i_req_addr   = $urandom;
      d_req_addr   = $urandom;
      i_req_rw     = $urandom_range(0, 1) == 1;
      d_req_rw     = $urandom_range(0, 1) == 1;
      i_req_wdata  = {$urandom, $urandom, $urandom, $urandom};
      d_req_wdata  = {$urandom, $urandom, $urandom, $urandom};
      m_req_ready  = $urandom_range(0, 1) == 1;
      m_resp_valid = ($urandom_range(0, 4) < 2);
      m_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    RESET = 0;
    idle_inputs();
    m_req_ready = 1; m_resp_valid = 1;
    for (int k = 0; k < 4; k++) cycle();
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, cache-line width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port i_req_valid, input, 1, icache line request pending.
REQ-006 The block SHALL have port i_req_addr, input, ADDR_W, icache line address.
REQ-007 The block SHALL have port i_req_rw, input, 1, icache request type: 1=write, 0=read.
REQ-008 The block SHALL have port i_req_wdata, input, LINE_W, icache writeback line.
REQ-009 The block SHALL have port i_req_ready, output, 1, icache request accepted.
REQ-010 The block SHALL have port i_resp_valid, output, 1, icache response strobe.
REQ-011 The block SHALL have port i_resp_data, output, LINE_W, icache refill line.
REQ-012 The block SHALL have ports d_req_valid, d_req_addr, d_req_rw, d_req_wdata, d_req_ready, d_resp_valid and d_resp_data, identical to REQ-005..011 but serving the dcache.
REQ-013 The block SHALL have port m_req_valid, output, 1, memory request valid.
REQ-014 The block SHALL have port m_req_ready, input, 1, memory accepts request.
REQ-015 The block SHALL have ports m_req_addr (output, ADDR_W), m_req_rw (output, 1) and m_req_wdata (output, LINE_W), carrying the granted request fields.
REQ-016 The block SHALL have port m_resp_valid, input, 1, memory response strobe.
REQ-017 The block SHALL have port m_resp_data, input, LINE_W, memory read line.
REQ-018 The block SHALL have port grant_d, output, 1, owner of the current transaction: 1=dcache, 0=icache.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with exactly one memory transaction outstanding at a time.
REQ-020 In IDLE, if any x_req_valid=1, the block SHALL select the winner, pulse its x_req_ready for that cycle, latch addr/rw/wdata, set grant_d, and go to ISSUE.
REQ-021 A requester not selected in IDLE SHALL see x_req_ready=0, and its x_req_ready SHALL be 0 in all other states.
REQ-022 In ISSUE, the block SHALL drive m_req_valid=1 with the latched fields stable until m_req_ready=1; on that handshake it SHALL go to WAIT.
REQ-023 If m_resp_valid=1 in the same cycle as the ISSUE handshake, the block SHALL capture the data and go directly to RESP.
REQ-024 In WAIT, on m_resp_valid=1 the block SHALL capture m_resp_data and go to RESP.
REQ-025 m_resp_valid SHALL be ignored in IDLE and RESP.
REQ-026 In RESP, the block SHALL assert the owner's x_resp_valid for exactly 1 cycle with the captured line (all zeros for writes), then return to IDLE.
REQ-027 Minimum latency, with zero-wait memory, SHALL be: accept at cycle N, m_req_valid at N+1, x_resp_valid at N+2.
REQ-028 The next request SHALL be accepted no earlier than the cycle after RESP.
REQ-029 m_req_addr, m_req_rw and m_req_wdata SHALL be 0 outside ISSUE; x_resp_data SHALL be 0 except during the owner's RESP cycle.
REQ-030 A requester dropping valid in IDLE SHALL simply not be granted, and changes to requester inputs after acceptance SHALL not affect the transaction.

Reset
REQ-031 On RESET=1 at a clock edge, the FSM SHALL return to IDLE, with all outputs 0, grant_d=0 and latches cleared from the next cycle, including mid-transaction.
REQ-032 After reset, a stale m_resp_valid SHALL be ignored, no x_resp_valid SHALL be generated for the aborted transaction, and no requester SHALL be accepted while RESET=1.

Configuration
REQ-033 With macro CACHE_ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester not granted last; a last-grant flop resets to icache, so the first tie goes to dcache.
REQ-034 Without CACHE_ARB_ROUND_ROBIN_EN, the dcache SHALL always win ties, and no last-grant state SHALL exist.

Verification
REQ-035 The bench SHALL cover: d read 0x0000_1040, memory ready immediately, response 1 cycle later with line 0xA5..A5 -> d_req_ready at N, m_req_valid at N+1, d_resp_valid at N+2 with 0xA5..A5, i_resp_valid stays 0.
REQ-036 The bench SHALL cover: i and d both valid in IDLE, back-to-back, 4 transactions -> without macro order d,d,d,d while d held; with macro order d,i,d,i.
REQ-037 The bench SHALL cover: d write 0x0000_2000 with wdata 0x1234..., m_req_ready held 0 for 5 cycles -> m_req fields stable for 6 cycles, then d_resp_valid with data 0.
REQ-038 The bench SHALL cover: RESET=1 in WAIT, then m_resp_valid the cycle after reset -> no x_resp_valid, FSM in IDLE, new i request accepted normally.
REQ-039 The bench SHALL cover: m_req_ready=1 and m_resp_valid=1 in the same cycle -> WAIT skipped, owner resp_valid on the next cycle with the captured data.
